hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Sequences stall/flush of the F/D, D/E, E/M and M/W pipeline registers and selects the operand forwarding paths for the Execute stage.
- Tracks multi-cycle data-memory waits with a registered FSM and a timeout counter; a timeout freezes the pipeline with a sticky error.
- Sits beside the decode/execute datapath; its StallE/FlushE outputs drive the D/E register directly.

Parameters:
- TIMEOUT, 16, number of consecutive MEMWAIT cycles before entering ERR (≥2).
- CNT_W, 5, width of the wait counter (must hold TIMEOUT).
- LOAD_SRC, 2'b01, ResultSrcE encoding identifying a load.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5  sources and destination of the instruction in Execute.
- ResultSrcE  in  2  result select of the instruction in Execute.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- RdM, RdW  in  5  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback.
- MemReqM  in  1  load/store active in Memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC and the F/D, D/E, E/M registers.
- FlushD, FlushE, FlushW  out  1  insert a bubble into F/D, D/E, M/W.
- ForwardAE, ForwardBE  out  2  operand select: 00 = RF, 01 = ResultW, 10 = ALUResultM.
- MemErr  out  1  sticky memory-timeout flag.
- State  out  2  FSM state, for debug.

Behaviour:
- FSM states: RUN = 00, MEMWAIT = 01, ERR = 10. Wait counter cnt is CNT_W bits.
- Reset (rst low, async): State = RUN, cnt = 0, MemErr = 0. While rst is low, all Stall* = 0, FlushD = FlushE = FlushW = 1, Forward* = 00.
- Forwarding (combinational, all states). ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E; else 01 if RegWriteW && RdW != 0 && RdW == Rs1E; else 00. The Memory match wins when both match. ForwardBE uses Rs2E with the same rule.
- memwait = MemReqM && !MemReadyM.
- lwStall = (ResultSrcE == LOAD_SRC) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- RUN, memwait = 1: StallF/D/E/M = 1, FlushW = 1, no other flush. Next state MEMWAIT, cnt = 1.
- RUN, memwait = 0, PCSrcE = 1: FlushD = FlushE = 1, no stall. The branch suppresses lwStall.
- RUN, memwait = 0, PCSrcE = 0, lwStall = 1: StallF = StallD = 1, FlushE = 1.
- RUN otherwise: all Stall*/Flush* = 0.
- MEMWAIT, MemReadyM = 0: same outputs as the memwait case. cnt increments. When cnt == TIMEOUT-1 at the edge, next state is ERR and MemErr sets.
- MEMWAIT, MemReadyM = 1: stalls drop the same cycle; outputs follow the RUN priority (PCSrcE, then lwStall). Next state RUN, cnt = 0.
- Deferral: PCSrcE and lwStall are ignored while memwait is asserted. They remain valid in the held E stage and act once memory is ready.
- ERR: all Stall* = 1, FlushW = 1, FlushD = FlushE = 0. MemErr = 1. Only reset leaves ERR.
- MemReqM dropping while in MEMWAIT is treated as MemReadyM = 1 (return to RUN).
- Counter saturates and never wraps.
- Reset asserted mid-MEMWAIT returns to RUN immediately with cnt = 0.

Test Plan:
- Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5, Rs2E = 0 -> ForwardAE = 10, ForwardBE = 00. Then RegWriteM = 0 -> ForwardAE = 01. Then RdW = 0 -> ForwardAE = 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7, PCSrcE = 0 -> StallF = StallD = FlushE = 1 for exactly that cycle. Same stimulus with RdE = 0 -> no stall.
- Branch priority: lwStall condition and PCSrcE = 1 together -> FlushD = FlushE = 1, StallF = StallD = 0.
- Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles, then 1 -> State 00→01→01→01→00. Stall F/D/E/M and FlushW high for the first 3 cycles, low on the ready cycle. PCSrcE held at 1 throughout -> FlushD/FlushE only on the ready cycle.
- Timeout: TIMEOUT = 4, MemReadyM held 0 -> ERR after 4 stalled cycles, MemErr = 1. MemReadyM = 1 afterwards -> stays in ERR. rst pulse low -> State = 00, MemErr = 0.
- Async reset: assert rst between clock edges mid-MEMWAIT -> State = 00 and FlushD/E/W = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing and EX operand forwarding for the 5-stage RV32I pipeline; all outputs are combinational
// from current inputs and registered FSM state, and a data-memory wait holds the whole pipeline until ready or timeout.
module hazard_ctrl #(
    parameter int         TIMEOUT  = 16,
    parameter int         CNT_W    = 5,
    parameter logic [1:0] LOAD_SRC = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemErr,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERR     = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           stateQ;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             memErrQ;
    logic             memErrNext;

    logic memWait;
    logic lwStall;

    // A dropped request counts as completion, so one term covers both exits from the wait.
    assign memWait = MemReqM && !MemReadyM;
    assign lwStall = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic       wrM,
        input logic [4:0] rdMem,
        input logic       wrW,
        input logic [4:0] rdWb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wrM && (rdMem != 5'd0) && (rdMem == rs)) begin
            sel = 2'b10;
        end else if (wrW && (rdWb != 5'd0) && (rdWb == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ  <= RUN;
            cnt     <= '0;
            memErrQ <= 1'b0;
        end else begin
            stateQ  <= stateNext;
            cnt     <= cntNext;
            memErrQ <= memErrNext;
        end
    end

    always_comb begin
        stateNext  = stateQ;
        cntNext    = cnt;
        memErrNext = memErrQ;
        case (stateQ)
            RUN: begin
                if (memWait) begin
                    stateNext = MEMWAIT;
                    cntNext   = CNT_ONE;
                end
            end
            MEMWAIT: begin
                if (memWait) begin
                    cntNext = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        stateNext  = ERR;
                        memErrNext = 1'b1;
                    end
                end else begin
                    stateNext = RUN;
                    cntNext   = '0;
                end
            end
            ERR: begin
                memErrNext = 1'b1;
            end
            default: begin
                stateNext = RUN;
                cntNext   = '0;
            end
        endcase
    end

    // RUN and MEMWAIT share one priority: memory wait, then taken branch, then load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (stateQ == ERR || memWait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lwStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            ForwardAE = fwdSel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwdSel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

    assign MemErr = memErrQ;
    assign State  = stateQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed plan cases followed by randomized traffic against a cycle-level model.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE, State;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5), .LOAD_SRC(2'b01)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .State(State)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic [1:0] resSrcE;
        logic       pcSrcE, regWriteM, regWriteW, memReq, memReady;
    } stim_t;

    // stall = {F,D,E,M}, flush = {D,E,W}
    typedef struct packed {
        logic [3:0] stall;
        logic [2:0] flush;
        logic [1:0] fwdA;
        logic [1:0] fwdB;
        logic       memErr;
        logic [1:0] state;
    } exp_t;

    exp_t  expQ[$];
    int    checks   = 0;
    int    failures = 0;
    int    cycle    = 0;

    // Reference model: how many cycles the current access has waited, and whether we have timed out.
    int    waitCycles = 0;
    bit    timedOut   = 1'b0;
    stim_t cur;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1;
        s.rs1D = 0; s.rs2D = 0; s.rs1E = 0; s.rs2E = 0; s.rdE = 0; s.rdM = 0; s.rdW = 0;
        s.resSrcE = 2'b00; s.pcSrcE = 0; s.regWriteM = 0; s.regWriteW = 0;
        s.memReq = 0; s.memReady = 0;
        return s;
    endfunction

    function automatic logic [1:0] fwdRef(input stim_t s, input logic [4:0] rs);
        if (s.regWriteM && s.rdM != 0 && s.rdM == rs) return 2'b10;
        if (s.regWriteW && s.rdW != 0 && s.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit   waiting;
        bit   loadUse;
        e = '0;
        if (!s.rst) begin
            e.flush = 3'b111;
            return e;
        end
        e.fwdA   = fwdRef(s, s.rs1E);
        e.fwdB   = fwdRef(s, s.rs2E);
        e.memErr = timedOut;
        e.state  = timedOut ? 2'd2 : (waitCycles > 0 ? 2'd1 : 2'd0);
        waiting  = s.memReq && !s.memReady;
        loadUse  = (s.resSrcE == 2'b01) && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
        if (timedOut || waiting) begin
            e.stall = 4'b1111;
            e.flush = 3'b001;
        end else if (s.pcSrcE) begin
            e.flush = 3'b110;
        end else if (loadUse) begin
            e.stall = 4'b1100;
            e.flush = 3'b010;
        end
        return e;
    endfunction

    task automatic clockEdgeModel();
        if (!cur.rst) begin
            waitCycles = 0;
            timedOut   = 1'b0;
        end else if (!timedOut) begin
            if (cur.memReq && !cur.memReady) begin
                if (waitCycles + 1 >= TIMEOUT) timedOut = 1'b1;
                else waitCycles = waitCycles + 1;
            end else begin
                waitCycles = 0;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        @(posedge clk);
        clockEdgeModel();
        #1;
        rst = s.rst;
        Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E; RdE = s.rdE;
        RdM = s.rdM; RdW = s.rdW; ResultSrcE = s.resSrcE; PCSrcE = s.pcSrcE;
        RegWriteM = s.regWriteM; RegWriteW = s.regWriteW;
        MemReqM = s.memReq; MemReadyM = s.memReady;
        cur = s;
        if (!s.rst) begin
            waitCycles = 0;
            timedOut   = 1'b0;
        end
        expQ.push_back(predict(s));
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cycle, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("stall", {StallF, StallD, StallE, StallM}, e.stall);
                check("flush", {1'b0, FlushD, FlushE, FlushW}, {1'b0, e.flush});
                check("fwd", {ForwardAE, ForwardBE}, {e.fwdA, e.fwdB});
                check("state_err", {1'b0, MemErr, State}, {1'b0, e.memErr, e.state});
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        s = idle();
        s.rst = 1'b0;
        cur = s;
        rst = 1'b0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;

        drive(s); drive(s);
        s = idle(); drive(s);

        // forwarding priority and x0 suppression
        s.rdM = 5; s.regWriteM = 1; s.rdW = 5; s.regWriteW = 1; s.rs1E = 5; drive(s);
        s.regWriteM = 0; drive(s);
        s.rdW = 0; drive(s);

        // load-use, load into x0, branch overriding load-use
        s = idle(); s.resSrcE = 2'b01; s.rdE = 7; s.rs2D = 7; drive(s);
        s.rdE = 0; drive(s);
        s.rdE = 7; s.pcSrcE = 1; drive(s);

        // 3-cycle memory wait with a branch deferred to the ready cycle
        s = idle(); s.memReq = 1; s.pcSrcE = 1; repeat (3) drive(s);
        s.memReady = 1; drive(s);
        s = idle(); drive(s);

        // timeout into sticky error, recovery only by reset
        s = idle(); s.memReq = 1; repeat (6) drive(s);
        s.memReady = 1; repeat (2) drive(s);
        s.rst = 0; drive(s);
        s = idle(); drive(s);

        // reset asserted between edges during a wait
        s = idle(); s.memReq = 1; repeat (2) drive(s);
        s.rst = 0; drive(s);
        s = idle(); drive(s);

        for (int i = 0; i < 3000; i++) begin
            s.rs1D = 5'($urandom_range(0, 3)); s.rs2D = 5'($urandom_range(0, 3));
            s.rs1E = 5'($urandom_range(0, 3)); s.rs2E = 5'($urandom_range(0, 3));
            s.rdE  = 5'($urandom_range(0, 3)); s.rdM  = 5'($urandom_range(0, 3));
            s.rdW  = 5'($urandom_range(0, 3));
            s.resSrcE   = 2'($urandom_range(0, 3));
            s.pcSrcE    = ($urandom_range(0, 5) == 0);
            s.regWriteM = 1'($urandom_range(0, 1));
            s.regWriteW = 1'($urandom_range(0, 1));
            s.memReq    = ($urandom_range(0, 2) == 0);
            s.memReady  = 1'($urandom_range(0, 1));
            s.rst       = timedOut ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 99) != 0);
            drive(s);
        end

        s = idle(); drive(s);
        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain cycle=%0d got=%0d want=0", cycle, expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
